// File: rtl/pll_rst_pkg.sv
// Shared types and constants for the PLL reset sequencer.
package pll_rst_pkg;

    localparam int unsigned RELOCK_W = 8;
    localparam int unsigned STATE_W  = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_PLL_RST   = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABLE    = 3'd2,
        ST_RELEASE   = 3'd3,
        ST_RUN       = 3'd4,
        ST_FAULT     = 3'd5
    } state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous status inputs.
module sync_2ff #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pll_reset_sequencer.sv
// PLL reset/lock supervisor with staggered release of downstream domain resets,
// automatic re-sequencing on loss of lock and a fault after bounded retries.
module pll_reset_sequencer
    import pll_rst_pkg::*;
#(
    parameter int unsigned NUM_CH             = 4,
    parameter int unsigned PLL_RST_CYCLES     = 8,
    parameter int unsigned LOCK_STABLE_CYCLES = 1024,
    parameter int unsigned STAGGER_CYCLES     = 16,
    parameter int unsigned LOCK_TIMEOUT       = 65535,
    parameter int unsigned MAX_RETRY          = 3,
    parameter int unsigned CNT_W              = 16
) (
    input  logic                gclk,
    input  logic                reset,
    input  logic                pll_locked,
    input  logic                soft_rst,
    output logic                pll_rst,
    output logic [NUM_CH-1:0]   rst_out,
    output logic                all_ready,
    output logic                fault,
    output logic [RELOCK_W-1:0] relock_cnt,
    output logic [STATE_W-1:0]  state_dbg
);

    localparam int unsigned RETRY_W = $clog2(MAX_RETRY + 1);

    state_t              state, state_n;
    logic [CNT_W-1:0]    cnt, cnt_n;
    logic [RETRY_W-1:0]  retry, retry_n, retry_inc;
    logic [RELOCK_W-1:0] relock_n;
    logic [NUM_CH-1:0]   rst_out_n, clr_mask;
    logic                pll_rst_n, all_ready_n, fault_n;
    logic                restart;
    logic                lock_s;

    sync_2ff #(.WIDTH(1)) u_lock_sync (
        .clk   (gclk),
        .reset (reset),
        .d     (pll_locked),
        .q     (lock_s)
    );

    assign state_dbg = state;

    // State and registered outputs
    always_ff @(posedge gclk) begin
        if (reset) begin
            state      <= ST_PLL_RST;
            cnt        <= '0;
            retry      <= '0;
            relock_cnt <= '0;
            pll_rst    <= 1'b1;
            rst_out    <= '1;
            all_ready  <= 1'b0;
            fault      <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            retry      <= retry_n;
            relock_cnt <= relock_n;
            pll_rst    <= pll_rst_n;
            rst_out    <= rst_out_n;
            all_ready  <= all_ready_n;
            fault      <= fault_n;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_n   = state;
        cnt_n     = cnt + CNT_W'(1);
        retry_n   = retry;
        retry_inc = retry + RETRY_W'(1);
        relock_n  = relock_cnt;
        restart   = 1'b0;
        clr_mask  = '0;
        rst_out_n = '1;

        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (cnt == CNT_W'(i * STAGGER_CYCLES)) clr_mask[i] = 1'b1;
        end

        case (state)
            ST_PLL_RST: begin
                if (cnt == CNT_W'(PLL_RST_CYCLES - 1)) state_n = ST_WAIT_LOCK;
            end
            ST_WAIT_LOCK: begin
                if (lock_s) begin
                    state_n = ST_STABLE;
                end else if (cnt == CNT_W'(LOCK_TIMEOUT - 1)) begin
                    retry_n = retry_inc;
                    state_n = (retry_inc == RETRY_W'(MAX_RETRY)) ? ST_FAULT : ST_PLL_RST;
                end
            end
            ST_STABLE: begin
                if (!lock_s) begin
                    state_n = ST_WAIT_LOCK;
                end else if (cnt == CNT_W'(LOCK_STABLE_CYCLES - 1)) begin
                    state_n = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                rst_out_n = rst_out & ~clr_mask;
                if (!lock_s) begin
                    state_n = ST_PLL_RST;
                end else if (cnt == CNT_W'((NUM_CH - 1) * STAGGER_CYCLES)) begin
                    state_n = ST_RUN;
                end
            end
            ST_RUN: begin
                rst_out_n = '0;
                if (!lock_s) begin
                    state_n = ST_PLL_RST;
                    retry_n = '0;
                    if (relock_cnt != '1) relock_n = relock_cnt + RELOCK_W'(1);
                end
            end
            ST_FAULT: begin
                state_n = ST_FAULT;
            end
            default: begin
                state_n = ST_PLL_RST;
            end
        endcase

        // Software restart overrides everything, including a concurrent lock loss
        if (soft_rst) begin
            state_n  = ST_PLL_RST;
            retry_n  = '0;
            relock_n = relock_cnt;
            restart  = 1'b1;
        end

        if (state_n != state || restart) cnt_n = '0;

        if (!(state_n inside {ST_RELEASE, ST_RUN})) rst_out_n = '1;

        pll_rst_n   = (state_n inside {ST_PLL_RST, ST_FAULT});
        all_ready_n = (state_n == ST_RUN);
        fault_n     = (state_n == ST_FAULT);
    end

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed self-checking bench for pll_reset_sequencer with small parameters.
module tb_pll_reset_sequencer;

    logic       gclk;
    logic       reset;
    logic       pll_locked;
    logic       soft_rst;
    logic       pll_rst;
    logic [2:0] rst_out;
    logic       all_ready;
    logic       fault;
    logic [7:0] relock_cnt;
    logic [2:0] state_dbg;

    int n_checks = 0;
    int n_fail   = 0;

    pll_reset_sequencer #(
        .NUM_CH             (3),
        .PLL_RST_CYCLES     (4),
        .LOCK_STABLE_CYCLES (8),
        .STAGGER_CYCLES     (2),
        .LOCK_TIMEOUT       (20),
        .MAX_RETRY          (2),
        .CNT_W              (8)
    ) dut (
        .gclk       (gclk),
        .reset      (reset),
        .pll_locked (pll_locked),
        .soft_rst   (soft_rst),
        .pll_rst    (pll_rst),
        .rst_out    (rst_out),
        .all_ready  (all_ready),
        .fault      (fault),
        .relock_cnt (relock_cnt),
        .state_dbg  (state_dbg)
    );

    initial gclk = 1'b0;
    always #5 gclk = ~gclk;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge gclk);
            #1;
        end
    endtask

    // Leaves the bench just after the last reset edge (cycle 0 begins)
    task automatic apply_reset();
        reset    = 1'b1;
        soft_rst = 1'b0;
        tick(2);
        reset = 1'b0;
    endtask

    task automatic wait_state(input logic [2:0] tgt, input int budget);
        int n = 0;
        while (state_dbg !== tgt && n < budget) begin
            tick(1);
            n++;
        end
        n_checks++;
        if (state_dbg !== tgt) begin
            n_fail++;
            $display("FAIL wait_state got=%0d exp=%0d", state_dbg, tgt);
        end
    endtask

    task automatic test_reset();
        logic [16:0] obs;
        pll_locked = 1'b0;
        reset      = 1'b1;
        soft_rst   = 1'b1;
        tick(2);
        obs = {pll_rst, rst_out, all_ready, fault, state_dbg, relock_cnt};
        n_checks++;
        if (obs !== {1'b1, 3'b111, 1'b0, 1'b0, 3'd0, 8'd0}) begin
            n_fail++;
            $display("FAIL reset got=%b exp=%b", obs, {1'b1, 3'b111, 1'b0, 1'b0, 3'd0, 8'd0});
        end
        soft_rst = 1'b0;
        reset    = 1'b0;
    endtask

    task automatic test_nominal();
        logic [8:0] obs, exp;
        logic [2:0] e_st, e_ro;
        pll_locked = 1'b0;
        apply_reset();
        for (int c = 0; c <= 24; c++) begin
            if (c == 6) pll_locked = 1'b1;
            e_st = (c <= 3) ? 3'd0 : (c <= 8) ? 3'd1 : (c <= 16) ? 3'd2 : (c <= 21) ? 3'd3 : 3'd4;
            e_ro = (c <= 17) ? 3'b111 : (c <= 19) ? 3'b110 : (c <= 21) ? 3'b100 : 3'b000;
            exp  = {(c <= 3) ? 1'b1 : 1'b0, e_ro, (c >= 22) ? 1'b1 : 1'b0, 1'b0, e_st};
            obs  = {pll_rst, rst_out, all_ready, fault, state_dbg};
            n_checks++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL nominal c=%0d got=%b exp=%b", c, obs, exp);
            end
            tick(1);
        end
    endtask

    task automatic test_glitch();
        logic [5:0] obs, exp;
        logic [2:0] e_st, e_ro;
        pll_locked = 1'b0;
        apply_reset();
        for (int c = 0; c <= 30; c++) begin
            if (c == 6)  pll_locked = 1'b1;
            if (c == 12) pll_locked = 1'b0;
            if (c == 13) pll_locked = 1'b1;
            e_st = (c <= 3) ? 3'd0 : (c <= 8) ? 3'd1 : (c <= 14) ? 3'd2 : (c == 15) ? 3'd1 :
                   (c <= 23) ? 3'd2 : (c <= 28) ? 3'd3 : 3'd4;
            e_ro = (c <= 24) ? 3'b111 : (c <= 26) ? 3'b110 : (c <= 28) ? 3'b100 : 3'b000;
            exp  = {e_ro, e_st};
            obs  = {rst_out, state_dbg};
            n_checks++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL glitch c=%0d got=%b exp=%b", c, obs, exp);
            end
            tick(1);
        end
    endtask

    task automatic test_fault();
        logic [8:0] obs, exp;
        logic [2:0] e_st;
        pll_locked = 1'b0;
        apply_reset();
        for (int c = 0; c <= 52; c++) begin
            e_st = (c <= 3) ? 3'd0 : (c <= 23) ? 3'd1 : (c <= 27) ? 3'd0 : (c <= 47) ? 3'd1 : 3'd5;
            exp  = {(e_st != 3'd1) ? 1'b1 : 1'b0, 3'b111, 1'b0, (c >= 48) ? 1'b1 : 1'b0, e_st};
            obs  = {pll_rst, rst_out, all_ready, fault, state_dbg};
            n_checks++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL fault c=%0d got=%b exp=%b", c, obs, exp);
            end
            tick(1);
        end
        soft_rst = 1'b1;
        tick(1);
        soft_rst = 1'b0;
        obs = {pll_rst, rst_out, all_ready, fault, state_dbg};
        exp = {1'b1, 3'b111, 1'b0, 1'b0, 3'd0};
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL fault_soft_rst got=%b exp=%b", obs, exp);
        end
    endtask

    // Lock loss in RUN followed by a full re-sequence back to RUN
    task automatic do_loss(input logic [7:0] exp_relock, input int idx);
        logic [12:0] obs, exp;
        pll_locked = 1'b0;
        for (int d = 1; d <= 3; d++) begin
            tick(1);
            exp = (d < 3) ? {3'b000, 1'b1, 3'd4, exp_relock - 8'd1}
                          : {3'b111, 1'b0, 3'd0, exp_relock};
            if (d == 3 && exp_relock == 8'd255 && relock_cnt == 8'd255 && idx > 255)
                exp = {3'b111, 1'b0, 3'd0, 8'd255};
            obs = {rst_out, all_ready, state_dbg, relock_cnt};
            if (d < 3 && idx > 255) exp[7:0] = 8'd255;
            n_checks++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL loss i=%0d d=%0d got=%b exp=%b", idx, d, obs, exp);
            end
        end
        pll_locked = 1'b1;
        tick(17);
        obs = {rst_out, all_ready, state_dbg, relock_cnt};
        exp = {3'b100, 1'b0, 3'd3, exp_relock};
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL resync_release i=%0d got=%b exp=%b", idx, obs, exp);
        end
        tick(1);
        obs = {rst_out, all_ready, state_dbg, relock_cnt};
        exp = {3'b000, 1'b1, 3'd4, exp_relock};
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL resync_run i=%0d got=%b exp=%b", idx, obs, exp);
        end
    endtask

    task automatic test_runtime_loss();
        pll_locked = 1'b1;
        apply_reset();
        wait_state(3'd4, 60);
        do_loss(8'd1, 1);
    endtask

    task automatic test_simultaneous();
        logic [12:0] obs, exp;
        pll_locked = 1'b0;
        tick(2);
        soft_rst = 1'b1;
        tick(1);
        soft_rst = 1'b0;
        obs = {rst_out, all_ready, state_dbg, relock_cnt};
        exp = {3'b111, 1'b0, 3'd0, 8'd1};
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL simultaneous got=%b exp=%b", obs, exp);
        end
        pll_locked = 1'b1;
        wait_state(3'd4, 60);
    endtask

    task automatic test_saturation();
        for (int i = 2; i <= 300; i++) begin
            do_loss((i >= 255) ? 8'd255 : 8'(i), i);
        end
    endtask

    task automatic test_reset_mid_release();
        logic [16:0] obs, exp;
        pll_locked = 1'b0;
        tick(3);
        pll_locked = 1'b1;
        tick(16);
        n_checks++;
        if (rst_out !== 3'b100) begin
            n_fail++;
            $display("FAIL mid_release_pre got=%b exp=%b", rst_out, 3'b100);
        end
        reset = 1'b1;
        tick(1);
        obs = {pll_rst, rst_out, all_ready, fault, state_dbg, relock_cnt};
        exp = {1'b1, 3'b111, 1'b0, 1'b0, 3'd0, 8'd0};
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL mid_release_reset got=%b exp=%b", obs, exp);
        end
        reset = 1'b0;
    endtask

    initial begin
        reset      = 1'b1;
        soft_rst   = 1'b0;
        pll_locked = 1'b0;
        test_reset();
        test_nominal();
        test_glitch();
        test_fault();
        test_runtime_loss();
        test_simultaneous();
        test_saturation();
        test_reset_mid_release();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
